// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered RISC-V writeback stage: result select, load extract, retire count
// Define WB_LOAD_EXT_EN to align and extend sub-word loads here; otherwise loads pass through raw.
module wb_stage #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [XLEN-1:0]      ALUResult,
  input  logic [XLEN-1:0]      ReadData,
  input  logic [XLEN-1:0]      PC_Plus_4,
  input  logic [XLEN-1:0]      PC_Target,
  input  logic [1:0]           ResultSrc,
  input  logic [2:0]           funct3_in,
  input  logic                 RegWrite_in,
  input  logic [REGADDR_W-1:0] Rd_in,
  output logic [XLEN-1:0]      Result,
  output logic                 RegWrite_out,
  output logic [REGADDR_W-1:0] Rd_out,
  output logic                 valid_out,
  output logic [CNT_W-1:0]     retire_count
);

  logic [XLEN-1:0]      load_val;
  logic [XLEN-1:0]      result_d;
  logic [XLEN-1:0]      result_q;
  logic [REGADDR_W-1:0] rd_q;
  logic                 regwrite_d;
  logic                 regwrite_q;
  logic                 valid_q;
  logic [CNT_W-1:0]     retire_q;

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  off;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_w;

  // Bit [2] of the offset only selects a word lane on 64-bit datapaths.
  always_comb begin
    off  = {(XLEN == 64) ? ALUResult[2] : 1'b0, ALUResult[1:0]};
    ld_b = 8'(ReadData >> {off, 3'b000});
    ld_h = 16'(ReadData >> {off[2:1], 4'b0000});
    ld_w = 32'(ReadData >> {off[2], 5'b00000});
    case (funct3_in)
      3'b000:  load_val = XLEN'($signed(ld_b));
      3'b100:  load_val = XLEN'(ld_b);
      3'b001:  load_val = XLEN'($signed(ld_h));
      3'b101:  load_val = XLEN'(ld_h);
      3'b010:  load_val = XLEN'($signed(ld_w));
      3'b110:  load_val = XLEN'(ld_w);
      default: load_val = ReadData;
    endcase
  end
`else
  logic unused_funct3;

  assign unused_funct3 = ^funct3_in;
  assign load_val      = ReadData;
`endif

  always_comb begin
    case (ResultSrc)
      2'b00:   result_d = ALUResult;
      2'b01:   result_d = load_val;
      2'b10:   result_d = PC_Plus_4;
      default: result_d = PC_Target;
    endcase
  end

  assign regwrite_d = RegWrite_in & valid_in & (Rd_in != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      retire_q   <= '0;
    end else if (flush) begin
      result_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      valid_q    <= 1'b0;
    end else if (!stall) begin
      result_q   <= result_d;
      rd_q       <= Rd_in;
      regwrite_q <= regwrite_d;
      valid_q    <= valid_in;
      if (valid_in) begin
        retire_q <= retire_q + CNT_W'(1);
      end
    end
  end

  // A held instruction must not write the register file again while stalled.
  assign RegWrite_out = regwrite_q & ~stall;
  assign Result       = result_q;
  assign Rd_out       = rd_q;
  assign valid_out    = valid_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with directed and random stimulus
module tb_wb_stage;

`ifdef WB_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    logic        r, st, fl, v;
    logic [31:0] alu, rdata, pc4, pct;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic        rw;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        val;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [31:0] ALUResult = '0, ReadData = '0, PC_Plus_4 = '0, PC_Target = '0;
  logic [1:0]  ResultSrc = '0;
  logic [2:0]  funct3_in = '0;
  logic        RegWrite_in = 1'b0;
  logic [4:0]  Rd_in = '0;

  logic [31:0] Result, Result4;
  logic        RegWrite_out, RegWrite_out4;
  logic [4:0]  Rd_out, Rd_out4;
  logic        valid_out, valid_out4;
  logic [31:0] retire_count;
  logic [3:0]  retire_count4;

  int total = 0;
  int bad = 0;

  exp_t exp_q[$];

  logic [31:0] m_res, m_cnt;
  logic [4:0]  m_rd;
  logic        m_rw, m_val;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ALUResult(ALUResult), .ReadData(ReadData), .PC_Plus_4(PC_Plus_4), .PC_Target(PC_Target),
    .ResultSrc(ResultSrc), .funct3_in(funct3_in), .RegWrite_in(RegWrite_in), .Rd_in(Rd_in),
    .Result(Result), .RegWrite_out(RegWrite_out), .Rd_out(Rd_out), .valid_out(valid_out),
    .retire_count(retire_count)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ALUResult(ALUResult), .ReadData(ReadData), .PC_Plus_4(PC_Plus_4), .PC_Target(PC_Target),
    .ResultSrc(ResultSrc), .funct3_in(funct3_in), .RegWrite_in(RegWrite_in), .Rd_in(Rd_in),
    .Result(Result4), .RegWrite_out(RegWrite_out4), .Rd_out(Rd_out4), .valid_out(valid_out4),
    .retire_count(retire_count4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference load value: pick the addressed byte/halfword lane arithmetically and sign-fix it.
  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] alu,
                                             input logic [2:0] f3);
    longint v;
    longint off;
    off = longint'(alu) % 4;
    if (!EXT) return rdata;
    case (f3)
      3'd0, 3'd4: begin
        v = (longint'(rdata) / (longint'(1) << (8 * off))) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (longint'(rdata) / (longint'(1) << (16 * (off / 2)))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rdata);
    endcase
    return 32'(v);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{r: 1'b0, st: 1'b0, fl: 1'b0, v: 1'b0, alu: '0, rdata: '0, pc4: '0, pct: '0,
          src: '0, f3: '0, rw: 1'b0, rd: '0};
    return s;
  endfunction

  function automatic stim_t alu_op(input logic [31:0] a, input logic [4:0] rd);
    stim_t s;
    s     = idle();
    s.v   = 1'b1;
    s.alu = a;
    s.rw  = 1'b1;
    s.rd  = rd;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic [31:0] sel;
    rst = s.r; stall = s.st; flush = s.fl; valid_in = s.v;
    ALUResult = s.alu; ReadData = s.rdata; PC_Plus_4 = s.pc4; PC_Target = s.pct;
    ResultSrc = s.src; funct3_in = s.f3; RegWrite_in = s.rw; Rd_in = s.rd;
    e = '{res: m_res, rd: m_rd, rw: m_rw & ~s.st, val: m_val, cnt: m_cnt};
    exp_q.push_back(e);
    case (s.src)
      2'd0:    sel = s.alu;
      2'd1:    sel = model_load(s.rdata, s.alu, s.f3);
      2'd2:    sel = s.pc4;
      default: sel = s.pct;
    endcase
    if (s.r) begin
      m_res = '0; m_rd = '0; m_rw = 1'b0; m_val = 1'b0; m_cnt = '0;
    end else if (s.fl) begin
      m_res = '0; m_rd = '0; m_rw = 1'b0; m_val = 1'b0;
    end else if (!s.st) begin
      m_res = sel; m_rd = s.rd; m_rw = s.rw && s.v && s.rd != 0; m_val = s.v;
      if (s.v) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_result", Result, e.res);
      chk("sb_rd", 32'(Rd_out), 32'(e.rd));
      chk("sb_regwrite", 32'(RegWrite_out), 32'(e.rw));
      chk("sb_valid", 32'(valid_out), 32'(e.val));
      chk("sb_count", retire_count, e.cnt);
      chk("sb_count4", 32'(retire_count4), e.cnt % 16);
    end
  end

  initial begin
    stim_t s;
    logic [31:0] cnt_before;
    @(posedge clk);
    #1;
    m_res = '0; m_rd = '0; m_rw = 1'b0; m_val = 1'b0; m_cnt = '0;

    step(alu_op(32'h1234, 5'd5));
    chk("first_result", Result, 32'h1234);
    chk("first_rd", 32'(Rd_out), 32'd5);
    chk("first_regwrite", 32'(RegWrite_out), 32'd1);
    chk("first_count", retire_count, 32'd1);

`ifdef WB_LOAD_EXT_EN
    s = alu_op(32'd3, 5'd7); s.src = 2'b01; s.rdata = 32'h80FF7F01; s.f3 = 3'b000;
    step(s);
    chk("lb_off3", Result, 32'hFFFFFF80);
    s.f3 = 3'b100;
    step(s);
    chk("lbu_off3", Result, 32'h00000080);
    s.alu = 32'd2; s.f3 = 3'b001;
    step(s);
    chk("lh_off2", Result, 32'hFFFF80FF);
    s.f3 = 3'b101;
    step(s);
    chk("lhu_off2", Result, 32'h000080FF);
`endif

    cnt_before = m_cnt;
    step(alu_op(32'h55, 5'd0));
    chk("x0_regwrite", 32'(RegWrite_out), 32'd0);
    chk("x0_count", retire_count, cnt_before + 1);

    step(alu_op(32'hAAAA0001, 5'd1));
    chk("stall_a1", Result, 32'hAAAA0001);
    s = alu_op(32'hBBBB0002, 5'd2); s.st = 1'b1;
    step(s);
    chk("stall_a2", Result, 32'hAAAA0001);
    step(alu_op(32'hCCCC0003, 5'd3));
    chk("stall_c", Result, 32'hCCCC0003);

    cnt_before = m_cnt;
    s = alu_op(32'h77, 5'd4); s.st = 1'b1; s.fl = 1'b1;
    step(s);
    chk("flush_stall_valid", 32'(valid_out), 32'd0);
    chk("flush_stall_count", retire_count, cnt_before);

    s = idle(); s.r = 1'b1;
    step(s);
    for (int i = 0; i < 15; i++) step(alu_op(32'(i), 5'(i + 1)));
    chk("wrap_pre", 32'(retire_count4), 32'd15);
    step(alu_op(32'h99, 5'd9));
    chk("wrap_post", 32'(retire_count4), 32'd0);
    chk("wrap_wide", retire_count, 32'd16);

    step(alu_op(32'hDEADBEEF, 5'd31));
    chk("pre_rst_result", Result, 32'hDEADBEEF);
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    s = idle(); s.r = 1'b1;
    step(s);
    chk("rst_result", Result, 32'd0);
    chk("rst_rd", 32'(Rd_out), 32'd0);
    chk("rst_regwrite", 32'(RegWrite_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_count", retire_count, 32'd0);

    for (int i = 0; i < 600; i++) begin
      s       = idle();
      s.r     = ($urandom_range(99) < 2);
      s.st    = ($urandom_range(99) < 20);
      s.fl    = ($urandom_range(99) < 10);
      s.v     = ($urandom_range(99) < 80);
      s.alu   = $urandom;
      s.rdata = $urandom;
      s.pc4   = $urandom;
      s.pct   = $urandom;
      s.src   = 2'($urandom_range(3));
      s.f3    = 3'($urandom_range(7));
      s.rw    = ($urandom_range(99) < 75);
      s.rd    = ($urandom_range(99) < 10) ? 5'd0 : 5'($urandom_range(31));
      step(s);
    end

    stall = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
